request_queue: RTL and testbench

REQUEST_QUEUE -- requirements
Module: request_queue

---
 rtl/global_defs.sv | 40 ++++
 rtl/queue_storage.sv | 29 ++
 rtl/request_queue.sv | 113 +++++++++++
 tb/tb_request_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_defs.sv
// Shared types and constants for the request queue slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package global_defs;

  localparam int QUEUE_DEPTH   = 16;
  localparam int ADDRESS_WIDTH = 32;

  typedef logic [31:0] int_t;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } parsed_op_t;

  // One line presented by the parser.
  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
    logic                     op_ready_s;
  } parser_out_struct_t;

  // Payload kept in storage; validity is derived from occupancy, not stored.
  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
  } queue_data_t;

  // Head view presented to the downstream controller.
  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
    logic                     valid;
  } queue_entry_t;

endpackage

// File: rtl/queue_storage.sv
// Register array holding queue payloads: one write port, one combinational read port.
// Latency: write visible on the read port the cycle after i_wr_en; read is zero-cycle.
// Backpressure: none; the controller only writes free slots.
module queue_storage
  import global_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_ptr,
  input  queue_data_t      i_wr_dat,
  input  logic [PTR_W-1:0] i_rd_ptr,
  output queue_data_t      o_rd_dat
);

  queue_data_t r_mem [DEPTH];

  // Payload write; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_ptr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_ptr];

endmodule

// File: rtl/request_queue.sv
// Circular request FIFO between parser and controller, with a simulated CPU clock.
// Latency: accepted line reaches head one cycle after acceptance; head is read combinationally.
// Backpressure: pending_request is raised combinationally whenever the presented line is not accepted.
module request_queue #(
  parameter int QUEUE_DEPTH = global_defs::QUEUE_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  global_defs::parser_out_struct_t in,
  input  logic                            pop,
  output global_defs::int_t               queue_time,
  output logic                            queue_full,
  output logic                            pending_request,
  output global_defs::queue_entry_t       head,
  output logic [$clog2(QUEUE_DEPTH):0]    count
);

  import global_defs::*;

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  int_t             r_queue_time;

  logic        w_is_nop;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_skip;
  queue_data_t w_wr_dat;
  queue_data_t w_rd_dat;

  // Fullness comes from the registered count only, so a same-cycle pop never frees a slot for a push.
  assign w_full   = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_is_nop = (in.opcode == NOP);

  // A line is taken once its timestamp is due; NOPs are consumed even when full.
  assign w_accept = in.op_ready_s && (in.time_cpu <= r_queue_time) && (w_is_nop || !w_full);
  assign w_push   = w_accept && !w_is_nop;
  assign w_pop    = pop && !w_empty;

  // Jump the clock forward only when nothing is queued that could still be due earlier.
  assign w_skip = w_empty && in.op_ready_s && !w_is_nop && (in.time_cpu > r_queue_time);

  assign w_wr_dat.opcode   = in.opcode;
  assign w_wr_dat.address  = in.address;
  assign w_wr_dat.time_cpu = in.time_cpu;

  queue_storage #(
    .DEPTH (QUEUE_DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk      (clk),
    .i_wr_en  (w_push),
    .i_wr_ptr (r_wr_ptr),
    .i_wr_dat (w_wr_dat),
    .i_rd_ptr (r_rd_ptr),
    .o_rd_dat (w_rd_dat)
  );

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Simulated CPU time: free-running, or loaded forward by a time-skip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_queue_time <= '0;
    end else if (w_skip) begin
      r_queue_time <= in.time_cpu;
    end else begin
      r_queue_time <= r_queue_time + 32'd1;
    end
  end

  // Head view: unwritten storage is masked to a NOP whenever the queue is empty.
  always_comb begin
    head          = '0;
    head.valid    = !w_empty;
    head.opcode   = w_empty ? NOP : w_rd_dat.opcode;
    head.address  = w_rd_dat.address;
    head.time_cpu = w_rd_dat.time_cpu;
  end

  assign queue_time      = r_queue_time;
  assign queue_full      = w_full;
  assign pending_request = in.op_ready_s && !w_accept;
  assign count           = r_count;

endmodule

// File: tb/tb_request_queue.sv
module tb_request_queue;
  import global_defs::*;

  logic               clk;
  logic               rst_n;
  parser_out_struct_t in_s;
  logic               pop_s;
  int_t               queue_time;
  logic               queue_full;
  logic               pending_request;
  queue_entry_t       head;
  logic [4:0]         count;

  queue_entry_t sb[$];
  queue_entry_t exp_e;
  int           n_checks;
  int           n_pass;

  request_queue #(.QUEUE_DEPTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in              (in_s),
    .pop             (pop_s),
    .queue_time      (queue_time),
    .queue_full      (queue_full),
    .pending_request (pending_request),
    .head            (head),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  function automatic parser_out_struct_t mk_line(parsed_op_t op, logic [31:0] a, int_t t, logic r);
    parser_out_struct_t l;
    l.opcode     = op;
    l.address    = a;
    l.time_cpu   = t;
    l.op_ready_s = r;
    return l;
  endfunction

  function automatic queue_entry_t mk_exp(parsed_op_t op, logic [31:0] a, int_t t);
    queue_entry_t e;
    e.opcode   = op;
    e.address  = a;
    e.time_cpu = t;
    e.valid    = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pop_s = 1'b0;
    in_s  = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    tick();
    tick();
    n_checks++; if (queue_time !== 32'd0) $display("FAIL reset_time got=%0d exp=0", queue_time); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (queue_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", queue_full); else n_pass++;
    n_checks++; if (head.valid !== 1'b0) $display("FAIL reset_head_valid got=%b exp=0", head.valid); else n_pass++;
    n_checks++; if (head.opcode !== NOP) $display("FAIL reset_head_op got=%0d exp=NOP", head.opcode); else n_pass++;
  endtask

  task automatic test_time_skip();
    in_s = mk_line(READ, 32'h1F40, 32'd5, 1'b1);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (pending_request !== 1'b1) $display("FAIL skip_pending_early got=%b exp=1", pending_request); else n_pass++;
    tick();
    n_checks++; if (queue_time !== 32'd5) $display("FAIL skip_time got=%0d exp=5", queue_time); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL skip_count0 got=%0d exp=0", count); else n_pass++;
    n_checks++; if (pending_request !== 1'b0) $display("FAIL skip_accept got=%b exp=0", pending_request); else n_pass++;
    sb.push_back(mk_exp(READ, 32'h1F40, 32'd5));
    tick();
    in_s = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    #1;
    n_checks++; if (count !== 5'd1) $display("FAIL skip_count1 got=%0d exp=1", count); else n_pass++;
    n_checks++; if (queue_time !== 32'd6) $display("FAIL skip_time_after got=%0d exp=6", queue_time); else n_pass++;
    n_checks++; if (head !== sb[0]) $display("FAIL skip_head got=%h exp=%h", head, sb[0]); else n_pass++;
    pop_s = 1'b1;
    exp_e = sb.pop_front();
    tick();
    pop_s = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0) $display("FAIL skip_pop_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (head.valid !== 1'b0) $display("FAIL skip_pop_valid got=%b exp=0", head.valid); else n_pass++;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 16; i++) begin
      in_s = mk_line((i % 2) ? WRITE : READ, 32'h100 + i, 32'd0, 1'b1);
      #1;
      n_checks++; if (pending_request !== 1'b0) $display("FAIL fill_pending[%0d] got=%b exp=0", i, pending_request); else n_pass++;
      sb.push_back(mk_exp((i % 2) ? WRITE : READ, 32'h100 + i, 32'd0));
      tick();
    end
    in_s = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    #1;
    n_checks++; if (queue_full !== 1'b1) $display("FAIL fill_full got=%b exp=1", queue_full); else n_pass++;
    n_checks++; if (count !== 5'd16) $display("FAIL fill_count got=%0d exp=16", count); else n_pass++;
    in_s  = mk_line(READ, 32'hDEAD, 32'd0, 1'b1);
    pop_s = 1'b1;
    #1;
    n_checks++; if (pending_request !== 1'b1) $display("FAIL full_pending_with_pop got=%b exp=1", pending_request); else n_pass++;
    pop_s = 1'b0;
    #1;
    n_checks++; if (pending_request !== 1'b1) $display("FAIL full_pending got=%b exp=1", pending_request); else n_pass++;
    tick();
    in_s = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    #1;
    n_checks++; if (count !== 5'd16) $display("FAIL full_unchanged_count got=%0d exp=16", count); else n_pass++;
    n_checks++; if (head !== sb[0]) $display("FAIL full_unchanged_head got=%h exp=%h", head, sb[0]); else n_pass++;
  endtask

  task automatic test_drain();
    pop_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_e = sb.pop_front();
      n_checks++; if (head !== exp_e) $display("FAIL drain_head[%0d] got=%h exp=%h", i, head, exp_e); else n_pass++;
      tick();
    end
    n_checks++; if (count !== 5'd0) $display("FAIL drain_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (head.valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", head.valid); else n_pass++;
    n_checks++; if (head.opcode !== NOP) $display("FAIL drain_op got=%0d exp=NOP", head.opcode); else n_pass++;
    n_checks++; if (queue_full !== 1'b0) $display("FAIL drain_full got=%b exp=0", queue_full); else n_pass++;
    repeat (3) tick();
    n_checks++; if (count !== 5'd0) $display("FAIL underflow_count got=%0d exp=0", count); else n_pass++;
    pop_s = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      in_s = mk_line(READ, 32'h200 + i, 32'd0, 1'b1);
      sb.push_back(mk_exp(READ, 32'h200 + i, 32'd0));
      tick();
    end
    n_checks++; if (count !== 5'd3) $display("FAIL b2b_fill_count got=%0d exp=3", count); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      in_s  = mk_line(WRITE, 32'h300 + i, 32'd0, 1'b1);
      pop_s = 1'b1;
      #1;
      exp_e = sb.pop_front();
      n_checks++; if (head !== exp_e) $display("FAIL b2b_head[%0d] got=%h exp=%h", i, head, exp_e); else n_pass++;
      sb.push_back(mk_exp(WRITE, 32'h300 + i, 32'd0));
      tick();
      n_checks++; if (count !== 5'd3) $display("FAIL b2b_count[%0d] got=%0d exp=3", i, count); else n_pass++;
    end
    in_s = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_e = sb.pop_front();
      n_checks++; if (head !== exp_e) $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, head, exp_e); else n_pass++;
      tick();
    end
    pop_s = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0) $display("FAIL b2b_end_count got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_async_reset();
    in_s = mk_line(READ, 32'h3000, 32'd93, 1'b1);
    tick();
    n_checks++; if (queue_time !== 32'd93) $display("FAIL ar_skip got=%0d exp=93", queue_time); else n_pass++;
    sb.push_back(mk_exp(READ, 32'h3000, 32'd93));
    tick();
    for (int i = 1; i < 7; i++) begin
      in_s = mk_line(READ, 32'h3000 + i, 32'd0, 1'b1);
      sb.push_back(mk_exp(READ, 32'h3000 + i, 32'd0));
      tick();
    end
    in_s = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    #1;
    n_checks++; if (queue_time !== 32'd100) $display("FAIL ar_pre_time got=%0d exp=100", queue_time); else n_pass++;
    n_checks++; if (count !== 5'd7) $display("FAIL ar_pre_count got=%0d exp=7", count); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (queue_time !== 32'd0) $display("FAIL ar_time got=%0d exp=0", queue_time); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL ar_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (head.valid !== 1'b0) $display("FAIL ar_valid got=%b exp=0", head.valid); else n_pass++;
    n_checks++; if (head.opcode !== NOP) $display("FAIL ar_op got=%0d exp=NOP", head.opcode); else n_pass++;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (queue_time !== 32'd0) $display("FAIL ar_release_time got=%0d exp=0", queue_time); else n_pass++;
    tick();
    n_checks++; if (queue_time !== 32'd1) $display("FAIL ar_count_up1 got=%0d exp=1", queue_time); else n_pass++;
    tick();
    n_checks++; if (queue_time !== 32'd2) $display("FAIL ar_count_up2 got=%0d exp=2", queue_time); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL ar_empty got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_nop();
    in_s = mk_line(NOP, 32'h4000, 32'd0, 1'b1);
    #1;
    n_checks++; if (pending_request !== 1'b0) $display("FAIL nop_pending got=%b exp=0", pending_request); else n_pass++;
    tick();
    n_checks++; if (count !== 5'd0) $display("FAIL nop_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (queue_time !== 32'd3) $display("FAIL nop_time got=%0d exp=3", queue_time); else n_pass++;
    in_s = mk_line(NOP, 32'h4000, 32'd50, 1'b1);
    #1;
    n_checks++; if (pending_request !== 1'b1) $display("FAIL nop_future_pending got=%b exp=1", pending_request); else n_pass++;
    tick();
    n_checks++; if (queue_time !== 32'd4) $display("FAIL nop_no_skip got=%0d exp=4", queue_time); else n_pass++;
  endtask

  task automatic test_no_skip_busy();
    in_s = mk_line(READ, 32'h5000, 32'd0, 1'b1);
    #1;
    n_checks++; if (head.valid !== 1'b0) $display("FAIL ns_head_early got=%b exp=0", head.valid); else n_pass++;
    sb.push_back(mk_exp(READ, 32'h5000, 32'd0));
    tick();
    in_s = mk_line(WRITE, 32'h5001, 32'd1000, 1'b1);
    #1;
    n_checks++; if (pending_request !== 1'b1) $display("FAIL ns_pending got=%b exp=1", pending_request); else n_pass++;
    tick();
    n_checks++; if (queue_time !== 32'd6) $display("FAIL ns_time got=%0d exp=6", queue_time); else n_pass++;
    n_checks++; if (count !== 5'd1) $display("FAIL ns_count got=%0d exp=1", count); else n_pass++;
    in_s  = mk_line(NOP, 32'h0, 32'd0, 1'b0);
    pop_s = 1'b1;
    #1;
    exp_e = sb.pop_front();
    n_checks++; if (head !== exp_e) $display("FAIL ns_head got=%h exp=%h", head, exp_e); else n_pass++;
    tick();
    pop_s = 1'b0;
    in_s  = mk_line(WRITE, 32'h5001, 32'd1000, 1'b1);
    tick();
    n_checks++; if (queue_time !== 32'd1000) $display("FAIL ns_skip_empty got=%0d exp=1000", queue_time); else n_pass++;
    in_s = mk_line(NOP, 32'h0, 32'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    pop_s    = 1'b0;
    in_s     = '0;
    test_reset();
    test_time_skip();
    test_fill_full();
    test_drain();
    test_back_to_back();
    test_async_reset();
    test_nop();
    test_no_skip_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
